// File: rtl/gtf_qpll_rst_pkg.sv
// Shared types and default timing for the GTF QPLL0 reset sequencer.
package gtf_qpll_rst_pkg;

    typedef enum logic [2:0] {
        ST_PWRDN     = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam int DEF_PD_CYCLES    = 16;
    localparam int DEF_RESET_CYCLES = 32;
    localparam int DEF_LOCK_TIMEOUT = 1024;
    localparam int DEF_LOCK_STABLE  = 64;
    localparam int DEF_MAX_RETRIES  = 3;

    // Control outputs that are a pure function of the state.
    typedef struct packed {
        logic pd;
        logic rst;
        logic done;
        logic fail;
    } ctl_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // One counter is shared by every timed state, so size it for the longest interval.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        return $clog2(max4(a, b, c, d) + 1);
    endfunction

    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            ST_PWRDN: begin
                c.pd  = 1'b1;
                c.rst = 1'b1;
            end
            ST_RST:  c.rst  = 1'b1;
            ST_DONE: c.done = 1'b1;
            ST_FAIL: c.fail = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gtf_cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module gtf_cdc_sync2 (
    input  logic clk,
    input  logic srst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both clear on reset so decisions start from a known level.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gtf_qpll_rst_seq.sv
// QPLL0 power-down / reset / lock-qualification sequencer with bounded retries.
// Optional macro GTF_QPLL_LOCKLOSS_RECOVER_EN: when defined, a lock loss after
// done re-runs the reset pulse; when undefined, done is sticky until restart/reset.
module gtf_qpll_rst_seq
    import gtf_qpll_rst_pkg::*;
#(
    parameter int PD_CYCLES    = DEF_PD_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input  logic       gtf_cm_drpclk,
    input  logic       gtf_cm_reset,
    input  logic       gtf_cm_qpll0_restart,
    input  logic       gtf_cm_qpll0lock,
    input  logic       gtf_cm_qpll0refclklost,
    output logic       gtf_cm_qpll0pd,
    output logic       gtf_cm_qpll0reset,
    output logic       gtf_cm_qpll0_done,
    output logic       gtf_cm_qpll0_fail,
    output logic [1:0] gtf_cm_qpll0_retry_cnt
);

    localparam int CNT_W = cnt_width(PD_CYCLES, RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

    // Each timed state leaves on the cycle its counter reads the last value.
    localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first saw lock is the first of the stable run,
    // so STABLE itself needs one cycle fewer (LOCK_STABLE is expected to be >= 2).
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'((LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    logic [1:0] async_in;
    logic [1:0] async_sync;
    logic       lock_sync;
    logic       lost_sync;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    ctl_t             ctl_q;

    assign async_in = {gtf_cm_qpll0refclklost, gtf_cm_qpll0lock};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        gtf_cdc_sync2 u_sync (
            .clk  (gtf_cm_drpclk),
            .srst (gtf_cm_reset),
            .d_i  (async_in[gi]),
            .q_o  (async_sync[gi])
        );
    end

    assign lock_sync = async_sync[0];
    assign lost_sync = async_sync[1];

    // Next-state, shared counter and retry bookkeeping; restart outranks everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        retry_d = retry_q;
        if (gtf_cm_qpll0_restart) begin
            state_d = ST_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PWRDN: begin
                    if (cnt_q == PD_LAST) begin
                        state_d = ST_RST;
                        cnt_d   = '0;
                    end
                end
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (lost_sync) begin
                        // No reference clock: the lock timeout must not run.
                        cnt_d = '0;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            state_d = ST_RST;
                            retry_d = retry_q + 2'd1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_sync) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end
                ST_DONE: begin
                    cnt_d = cnt_q;
`ifdef GTF_QPLL_LOCKLOSS_RECOVER_EN
                    if (!lock_sync) begin
                        state_d = ST_RST;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
`endif
                end
                ST_FAIL: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_PWRDN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers plus outputs decoded from the next state so they are flops.
    always_ff @(posedge gtf_cm_drpclk) begin
        if (gtf_cm_reset) begin
            state_q <= ST_PWRDN;
            cnt_q   <= '0;
            retry_q <= '0;
            ctl_q   <= decode_ctl(ST_PWRDN);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            ctl_q   <= decode_ctl(state_d);
        end
    end

    assign gtf_cm_qpll0pd         = ctl_q.pd;
    assign gtf_cm_qpll0reset      = ctl_q.rst;
    assign gtf_cm_qpll0_done      = ctl_q.done;
    assign gtf_cm_qpll0_fail      = ctl_q.fail;
    assign gtf_cm_qpll0_retry_cnt = retry_q;

endmodule

// File: doc/gtf_qpll_rst_seq.md
GTF_QPLL_RST_SEQ -- requirements
Module: gtf_qpll_rst_seq

Interface
REQ-001 SHALL have parameter PD_CYCLES, default 16: cycles QPLL is held in power-down after reset release.
REQ-002 SHALL have parameter RESET_CYCLES, default 32: width of the qpll0reset pulse.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024: cycles allowed for lock after the reset pulse ends.
REQ-004 SHALL have parameter LOCK_STABLE, default 64: consecutive synchronized-lock cycles required before done.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: reset retries after the first attempt before fail.
REQ-006 SHALL have ports as listed; one clock; reset is synchronous and active-high:
- gtf_cm_drpclk  in  1  free-running sequencer clock
- gtf_cm_reset  in  1  synchronous active-high reset
- gtf_cm_qpll0_restart  in  1  single-cycle restart request
- gtf_cm_qpll0lock  in  1  QPLL lock from GTF_COMMON, asynchronous
- gtf_cm_qpll0refclklost  in  1  refclk lost from GTF_COMMON, asynchronous
- gtf_cm_qpll0pd  out  1  QPLL power-down
- gtf_cm_qpll0reset  out  1  QPLL reset
- gtf_cm_qpll0_done  out  1  QPLL locked and stable
- gtf_cm_qpll0_fail  out  1  retries exhausted
- gtf_cm_qpll0_retry_cnt  out  2  retries used

Function
REQ-007 SHALL pass both asynchronous inputs through two-flop synchronizers; all decisions use synchronized values (2-cycle latency).
REQ-008 SHALL implement states PWRDN, RST, WAIT_LOCK, STABLE, DONE, FAIL with one shared cycle counter, cleared on every state entry.
REQ-009 PWRDN: pd=1, reset=1; after PD_CYCLES cycles -> RST.
REQ-010 RST: pd=0, reset=1; after RESET_CYCLES cycles -> WAIT_LOCK.
REQ-011 WAIT_LOCK: reset=0; lock_sync=1 -> STABLE; counter reaching LOCK_TIMEOUT -> RST if retry_cnt<MAX_RETRIES (retry_cnt+1), else FAIL.
REQ-012 WAIT_LOCK: refclklost_sync=1 SHALL hold the counter at 0 (timeout does not advance while refclk is absent).
REQ-013 STABLE: lock_sync=0 -> WAIT_LOCK (counter cleared, timeout restarts); LOCK_STABLE consecutive lock_sync=1 cycles -> DONE.
REQ-014 DONE: done=1; lock_sync=0 handled per REQ-020.
REQ-015 FAIL: fail=1, pd=0, reset=0; exit only via restart or reset.
REQ-016 gtf_cm_qpll0_restart=1 in any state SHALL force RST next cycle, clear retry_cnt, done, fail; restart has priority over all other transitions in the same cycle.
REQ-017 done and fail SHALL never be 1 simultaneously; retry_cnt saturates at MAX_RETRIES.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 gtf_cm_reset=1 SHALL, on the next edge, enter PWRDN with pd=1, reset=1, done=0, fail=0, retry_cnt=0, counter=0, synchronizer flops=0; reset mid-sequence restarts from PWRDN.

Configuration
REQ-020 Macro GTF_QPLL_LOCKLOSS_RECOVER_EN: defined -> lock_sync=0 in DONE drops done and enters RST with retry_cnt cleared; undefined -> DONE is sticky, done stays 1 regardless of lock.

Structure
REQ-021 Package gtf_qpll_rst_pkg SHALL hold the state enum and the default timing constants; counter width derived from max(PD_CYCLES, RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).
REQ-022 Synchronizer SHALL be sub-module gtf_cdc_sync2, instantiated once per asynchronous input.

Verification (defaults; cycle 0 = first edge after reset deasserts)
REQ-023 Reset released, lock rises at cycle 100 -> pd=1 cycles 0-15; reset=1 cycles 16-47; done=1 from cycle 166.
REQ-024 Lock never asserted -> three reset pulses after the first (retry_cnt 1,2,3), then fail=1 and retry_cnt=3.
REQ-025 Lock rises at cycle 100, drops at cycle 130 for 5 cycles -> STABLE abandoned, done delayed until 64 consecutive lock cycles after recovery.
REQ-026 refclklost held high cycles 48-2000, lock low -> no timeout or retry during hold; timeout 1024 cycles after refclklost_sync falls.
REQ-027 In DONE, lock drops: with macro -> done=0, reset pulse of 32 cycles; without -> done stays 1.
REQ-028 Restart pulsed in FAIL and mid-RST -> fail=0, retry_cnt=0, fresh 32-cycle reset pulse begins next cycle.
